// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   INSTR_BYTES      : bytes per instruction word (PC increment)
//   QUEUE_DEPTH      : entries in the fetch queue (fixed)
//   NOP              : canonical no-op encoding (addi x0,x0,0)
//   DEFAULT_RESET_PC : default PC loaded on reset
//   fetch_entry      : {pc, instr} pair carried through the fetch queue
package instruction_fetch_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned QUEUE_DEPTH      = 2;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry;

endpackage

// File: rtl/instruction_fetch_queue.sv
// Two-entry synchronous FIFO of fetch_entry with flush.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (zeroes all slots)
//   flush       : empties the queue; wins over push/pop
//   push, push_data : enqueue request and data (ignored when full without pop)
//   pop         : dequeue request (ignored when empty)
//   head        : registered head entry (slot 0)
//   full, empty : occupancy flags
// Handshake: an entry moves when the producer raises push and the queue
// has room (or is popping in the same cycle); the consumer's pop takes the
// head only while empty is low. Both may happen in one cycle.
module instruction_fetch_queue
  import instruction_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  fetch_entry push_data,
  input  logic       pop,
  output fetch_entry head,
  output logic       full,
  output logic       empty
);

  fetch_entry slot0;
  fetch_entry slot1;
  logic [1:0] count;
  logic       do_pop;
  logic       do_push;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'(QUEUE_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = slot0;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; with one entry the new word becomes the head,
          // with two the second slot advances and the new word takes the tail.
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: holds the PC, drives the instruction memory read
// port, captures the same-cycle instruction word into a 2-entry queue and
// presents {pc, instr} to decode.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   read_addr           : byte address to instruction memory (= PC)
//   instruction         : combinational memory data for read_addr
//   fetch_en            : allow a new fetch this cycle
//   redirect_valid/_pc  : taken branch/jump; flushes queue and reloads PC
//   out_valid/out_ready : decode handshake; transfer when both high
//   out_instr, out_pc   : queue head entry
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] read_addr,
  input  logic [31:0] instruction,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic [31:0] pc;
  logic        pop;
  logic        push;
  logic        q_full;
  logic        q_empty;
  fetch_entry  q_head;
  fetch_entry  new_entry;

  assign read_addr = pc;
  assign out_valid = ~q_empty;
  assign out_instr = q_head.instr;
  assign out_pc    = q_head.pc;

  assign pop       = out_valid & out_ready;
  // Redirect suppresses the push: the word at the old PC is on the wrong path.
  assign push      = fetch_en & ~redirect_valid & (~q_full | pop);
  assign new_entry = '{pc: pc, instr: instruction};

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~32'h0000_0003;
    end else if (push) begin
      pc <= pc + 32'(INSTR_BYTES);
    end
  end

  instruction_fetch_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (new_entry),
    .pop       (pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // clock/reset block
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] read_addr;
  logic [31:0] instruction;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  assign instruction = mem[read_addr[7:2]];

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .read_addr      (read_addr),
    .instruction    (instruction),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // behavioural model: PC, expected queue of {pc, instr}
  logic [63:0] exp_q [$];
  logic [31:0] m_pc;
  bit          m_after_reset;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    cmp("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    cmp("read_addr", read_addr, m_pc);
    if (exp_q.size() != 0) begin
      cmp("out_pc", out_pc, exp_q[0][63:32]);
      cmp("out_instr", out_instr, exp_q[0][31:0]);
    end else if (m_after_reset) begin
      cmp("out_pc_rst", out_pc, 32'h0);
      cmp("out_instr_rst", out_instr, 32'h0);
    end
  endtask

  // driver: apply one cycle of inputs, advance model, check after the edge
  task automatic step(input bit r, input bit fe, input bit rv,
                      input logic [31:0] rp, input bit rdy);
    int sz;
    bit pop;
    reset          = r;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
    sz  = exp_q.size();
    pop = (sz > 0) && rdy;
    if (r) begin
      m_pc = RESET_PC;
      exp_q.delete();
      m_after_reset = 1'b1;
    end else if (rv) begin
      m_pc = rp & 32'hFFFF_FFFC;
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (fe && (sz < 2 || pop)) begin
        exp_q.push_back({m_pc, mem[m_pc[7:2]]});
        m_pc = m_pc + 32'd4;
        m_after_reset = 1'b0;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
  endtask

  logic [31:0] prog [0:4];
  logic [31:0] held;

  initial begin
    prog[0] = 32'h00F00093; prog[1] = 32'h00A00093; prog[2] = 32'h001101B3;
    prog[3] = 32'h00117233; prog[4] = 32'h001162B3;
    for (int i = 0; i < 64; i++) mem[i] = (i < 5) ? prog[i] : $urandom;
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b0;

    // reset state
    do_reset();
    cmp("lit_rst_valid", {31'd0, out_valid}, 32'd0);
    cmp("lit_rst_addr", read_addr, 32'h0);
    cmp("lit_rst_pc", out_pc, 32'h0);
    cmp("lit_rst_instr", out_instr, 32'h0);

    // straight-line stream, one per cycle
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 32'h0, 1);
      cmp("lit_stream_pc", out_pc, 32'(4 * k));
      cmp("lit_stream_instr", out_instr, prog[k]);
    end

    // backpressure from cycle 0, then drain
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 1, 0, 32'h0, 0);
    cmp("lit_bp_addr", read_addr, 32'h8);
    cmp("lit_bp_instr", out_instr, 32'h00F00093);
    step(0, 1, 0, 32'h0, 1);
    cmp("lit_drain_pc1", out_pc, 32'h4);
    step(0, 1, 0, 32'h0, 1);
    cmp("lit_drain_pc2", out_pc, 32'h8);

    // redirect while full, misaligned target
    do_reset();
    for (int k = 0; k < 3; k++) step(0, 1, 0, 32'h0, 0);
    step(0, 1, 1, 32'h0000_000E, 0);
    cmp("lit_redir_valid", {31'd0, out_valid}, 32'd0);
    cmp("lit_redir_addr", read_addr, 32'hC);
    step(0, 1, 0, 32'h0, 1);
    cmp("lit_redir_pc", out_pc, 32'hC);
    cmp("lit_redir_instr", out_instr, 32'h00117233);

    // redirect together with pop at count 2
    do_reset();
    for (int k = 0; k < 3; k++) step(0, 1, 0, 32'h0, 0);
    cmp("lit_rp_head", out_pc, 32'h0);
    step(0, 1, 1, 32'h10, 1);
    cmp("lit_rp_empty", {31'd0, out_valid}, 32'd0);
    step(0, 1, 0, 32'h0, 1);
    cmp("lit_rp_next", out_pc, 32'h10);

    // fetch_en low for 3 cycles
    held = read_addr;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 32'h0, 1);
      cmp("lit_hold_addr", read_addr, held);
    end
    cmp("lit_hold_drained", {31'd0, out_valid}, 32'd0);
    step(0, 1, 0, 32'h0, 1);
    cmp("lit_resume_pc", out_pc, held);

    // reset with queue full and redirect pending
    for (int k = 0; k < 3; k++) step(0, 1, 0, 32'h0, 0);
    step(1, 1, 1, 32'h40, 1);
    cmp("lit_mid_rst_addr", read_addr, RESET_PC);
    cmp("lit_mid_rst_valid", {31'd0, out_valid}, 32'd0);
    cmp("lit_mid_rst_pc", out_pc, 32'h0);
    cmp("lit_mid_rst_instr", out_instr, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 10,
           $urandom,
           $urandom_range(0, 99) < 60);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
